// File: rtl/alu_hs_pkg.sv
// Shared opcodes, FSM states and opcode legality for the handshaked ALU.
// ALU_HS_MUL_EN enables opcode 1010 (iterative multiply) and the BUSY state.
package alu_hs_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

`ifdef ALU_HS_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  // Without the multiplier, 1010 joins the illegal range.
  function automatic logic op_is_legal(input logic [3:0] op);
`ifdef ALU_HS_MUL_EN
    return (op <= OP_MUL);
`else
    return (op < OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_hs_mul_seq.sv
// Shift-add multiplier, one multiplier bit per cycle, XLEN iterations.
// Instantiated by alu_hs only when ALU_HS_MUL_EN is defined.
module alu_hs_mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   count;
  logic            busy;

  // Only the low XLEN product bits are kept, so the multiplicand shifts within XLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      if (count == CW'(XLEN)) begin
        busy <= 1'b0;
      end else begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
    end
  end

  assign done    = busy && (count == CW'(XLEN));
  assign product = acc;

endmodule

// File: rtl/alu_hs.sv
// Handshaked RV32I ALU: single-cycle datapath, IDLE/BUSY/DONE FSM, registered result.
// ALU_HS_MUL_EN adds the iterative multiplier for opcode 1010; otherwise 1010 is illegal.
module alu_hs
  import alu_hs_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  state_t          state;
  state_t          next_state;
  state_t          accept_state;
  logic            accept;
  logic            load_alu;
  logic [XLEN-1:0] alu_result;
  logic [SHW-1:0]  shamt;

  assign shamt     = b[SHW-1:0];
  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = a + b;
      OP_SUB:  alu_result = a - b;
      OP_AND:  alu_result = a & b;
      OP_OR:   alu_result = a | b;
      OP_XOR:  alu_result = a ^ b;
      OP_SLL:  alu_result = a << shamt;
      OP_SRL:  alu_result = a >> shamt;
      OP_SRA:  alu_result = XLEN'($signed(a) >>> shamt);
      OP_SLT:  alu_result = XLEN'($signed(a) < $signed(b));
      OP_SLTU: alu_result = XLEN'(a < b);
      default: alu_result = '0;
    endcase
  end

`ifdef ALU_HS_MUL_EN
  logic            mul_start;
  logic            mul_done;
  logic            load_mul;
  logic [XLEN-1:0] mul_product;

  assign mul_start = accept && (accept_state == BUSY);
  assign load_mul  = (state == BUSY) && mul_done;

  alu_hs_mul_seq #(
    .XLEN(XLEN)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_product)
  );
`endif

  always_comb begin
    accept_state = DONE;
`ifdef ALU_HS_MUL_EN
    if (op == OP_MUL) begin
      accept_state = BUSY;
    end
`endif
  end

  assign load_alu = accept && (accept_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DONE with out_ready behaves like IDLE, so a new op can be taken on the retiring edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = accept_state;
        end
      end
`ifdef ALU_HS_MUL_EN
      BUSY: begin
        if (mul_done) begin
          next_state = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          next_state = accept ? accept_state : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      illegal <= 1'b0;
    end else if (load_alu) begin
      result  <= alu_result;
      illegal <= !op_is_legal(op);
    end
`ifdef ALU_HS_MUL_EN
    else if (load_mul) begin
      result  <= mul_product;
      illegal <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_hs.sv
// Self-checking bench for alu_hs: vector table for single-cycle ops plus
// hand-written multi-cycle sequences (mul, backpressure, reset).
module tb_alu_hs;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_illegal;
    string       name;
  } vector_t;

  localparam int NUM_VECTORS = 14;
  vector_t vectors [NUM_VECTORS];

  always #5 clk = ~clk;

  alu_hs #(
    .XLEN(XLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .illegal  (illegal)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] new_op, input logic [31:0] new_a, input logic [31:0] new_b);
    @(negedge clk);
    in_valid = 1'b1;
    op       = new_op;
    a        = new_a;
    b        = new_b;
  endtask

  task automatic runVector(input vector_t v);
    applyStimulus(v.op, v.a, v.b);
    #1;
    checkOutput({v.name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput({v.name, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({v.name, " result"}, result, v.exp_result);
    checkOutput({v.name, " illegal"}, 32'(illegal), 32'(v.exp_illegal));
  endtask

  // Counts edges after the accept edge until out_valid shows, tracking in_ready meanwhile.
  task automatic runMul(input string name, input logic [31:0] ma, input logic [31:0] mb,
                        input logic [31:0] exp_result, input logic exp_illegal, input int exp_edges);
    int  edges;
    logic ready_seen;
    applyStimulus(4'b1010, ma, mb);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    edges      = 0;
    ready_seen = 1'b0;
    while (!out_valid && edges < 60) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({name, " latency"}, 32'(edges), 32'(exp_edges));
    checkOutput({name, " in_ready while busy"}, 32'(ready_seen), 32'd0);
    checkOutput({name, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, " result"}, result, exp_result);
    checkOutput({name, " illegal"}, 32'(illegal), 32'(exp_illegal));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   stray;
    logic hold_ok;

    vectors[0]  = '{4'b0000, 32'd5,          32'd4,          32'd9,          1'b0, "add"};
    vectors[1]  = '{4'b0000, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0, "add wrap"};
    vectors[2]  = '{4'b0001, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, "sub"};
    vectors[3]  = '{4'b0010, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, "and"};
    vectors[4]  = '{4'b0011, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1'b0, "or"};
    vectors[5]  = '{4'b0100, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F,  1'b0, "xor"};
    vectors[6]  = '{4'b0111, 32'hFFFF_FE70,  32'd16,         32'hFFFF_FFFF,  1'b0, "sra"};
    vectors[7]  = '{4'b0110, 32'hFFFF_FE70,  32'd16,         32'h0000_FFFF,  1'b0, "srl"};
    vectors[8]  = '{4'b0101, 32'd1,          32'd33,         32'd2,          1'b0, "sll masked"};
    vectors[9]  = '{4'b0111, 32'h8000_0000,  32'hFFFF_FFE4,  32'hF800_0000,  1'b0, "sra masked"};
    vectors[10] = '{4'b1000, 32'hFFFF_FFB3,  32'd5528,       32'd1,          1'b0, "slt"};
    vectors[11] = '{4'b1001, 32'hFFFF_FFB3,  32'd5528,       32'd0,          1'b0, "sltu"};
    vectors[12] = '{4'b1100, 32'd12,         32'd34,         32'd0,          1'b1, "illegal 1100"};
    vectors[13] = '{4'b1111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1, "illegal 1111"};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'b0000;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset illegal", 32'(illegal), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NUM_VECTORS; i++) begin
      runVector(vectors[i]);
    end
    @(posedge clk);
    #1;

    // slt then sltu back to back: results on consecutive cycles
    applyStimulus(4'b1000, 32'hFFFF_FFB3, 32'd5528);
    @(posedge clk);
    #1;
    op = 4'b1001;
    checkOutput("b2b slt out_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b slt result", result, 32'd1);
    checkOutput("b2b in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("b2b sltu out_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b sltu result", result, 32'd0);
    @(posedge clk);
    #1;

`ifdef ALU_HS_MUL_EN
    runMul("mul 749*619", 32'd749, 32'd619, 32'd463631, 1'b0, 33);
    runMul("mul -3*7", 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 33);
`else
    runMul("mul disabled", 32'd749, 32'd619, 32'd0, 1'b1, 0);
`endif

    // Backpressure: result held for 3 cycles, then retire and accept on one edge
    out_ready = 1'b0;
    applyStimulus(4'b0000, 32'd10, 32'd20);
    @(posedge clk);
    #1;
    op      = 4'b0100;
    a       = 32'd6;
    b       = 32'd3;
    hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || result !== 32'd30 || in_ready) hold_ok = 1'b0;
    end
    checkOutput("backpressure hold", 32'(hold_ok), 32'd1);
    checkOutput("backpressure result", result, 32'd30);
    checkOutput("backpressure in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("release out_valid", 32'(out_valid), 32'd1);
    checkOutput("release new result", result, 32'd5);
    @(posedge clk);
    #1;
    checkOutput("release drained", 32'(out_valid), 32'd0);

    // Reset while a result waits in DONE
    out_ready = 1'b0;
    applyStimulus(4'b0000, 32'd100, 32'd23);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("done before reset", result, 32'd123);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset in DONE in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("reset in DONE out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in DONE result", result, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in DONE no result", 32'(out_valid), 32'd0);

`ifdef ALU_HS_MUL_EN
    // Reset ten cycles into a multiply: nothing must ever come out
    applyStimulus(4'b1010, 32'd749, 32'd619);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mul reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mul reset result", result, 32'd0);
    checkOutput("mul reset illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stray++;
    end
    checkOutput("mul reset no result", 32'(stray), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_hs.md
# alu_hs

Parametrised, handshaked ALU for the RV32I datapath. It is the successor to the combinational 3-bit-opcode ALU. It widens the opcode to 4 bits, adds signed and unsigned compare, and adds an optional iterative multiplier. Operands enter and results leave over valid/ready channels, so the block sits between the decode/issue stage and writeback and can stall either side.

## Interface
- `XLEN`, default 32: operand and result width; must be a power of two, ≥ 8.
- `SHW`, default `$clog2(XLEN)`: number of shift-amount bits taken from `b`; derived, not overridden.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request this cycle.
- `op`  in  4  operation code.
- `a`, `b`  in  `XLEN`  operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  `XLEN`  result.
- `illegal`  out  1  qualifies `result`; high when the opcode is unsupported.

## Operation
- Encoding (the 3-bit legacy codes are preserved with `op[3]=0`):
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 sll
  - 0110 srl
  - 0111 sra
  - 1000 slt (signed; result 1/0, zero-extended)
  - 1001 sltu
  - 1010 mul (low `XLEN` bits of the product)
  - 1011–1111 illegal
- Shifts use `b[SHW-1:0]` only; upper bits of `b` are ignored.
- add, sub and mul wrap modulo 2^`XLEN`; no flags.
- Illegal opcode: `result`=0, `illegal`=1, single-cycle path.
- FSM states:
  - IDLE → on accept: BUSY if the op is mul, else DONE.
  - BUSY: shift-add, one multiplier bit per cycle, `XLEN` iterations; then DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE, or take a new request in the same cycle (next state chosen as from IDLE).
- `in_ready` = !`rst` && (state==IDLE || (state==DONE && `out_ready`)).
- Accept = `in_valid` && `in_ready`. Operands and `op` are latched at accept; input changes afterwards have no effect.
- `result` and `illegal` are registered and held stable while `out_valid` && !`out_ready`.

## Timing
- Reset values: state IDLE, `out_valid`=0, `result`=0, `illegal`=0. `in_ready` is 0 in any cycle where `rst`=1.
- Non-mul latency: `out_valid` rises on the edge after accept (1 cycle). Throughput is 1/cycle when `out_ready` is held high.
- mul latency: `XLEN`+1 cycles from accept edge to `out_valid` (33 for `XLEN`=32). `in_ready`=0 throughout BUSY.
- Backpressure: DONE with !`out_ready` holds everything; `in_ready`=0.
- Simultaneous result handoff and new accept in DONE: the old result retires and the new op is latched on the same edge, with no bubble for non-mul ops.
- `rst` mid-BUSY or in DONE: the operation is discarded, no result is emitted, and outputs return to reset values on the next edge.

## Configuration
- `ALU_HS_MUL_EN` defined: opcode 1010 executes the iterative multiply and the BUSY state exists.
- `ALU_HS_MUL_EN` undefined: 1010 is treated as illegal (`result`=0, `illegal`=1, latency 1). The multiplier and BUSY state are not instantiated.

## Structure
- `alu_hs_pkg` contains:
  - the opcode localparams `OP_ADD` … `OP_MUL`;
  - the state enum (IDLE/BUSY/DONE);
  - a function `op_is_legal(op)` that honours `ALU_HS_MUL_EN`.
- Sub-module `alu_hs_mul_seq` holds the shift-add multiplier with start/done pulses and an `XLEN`-bit accumulator. It is instantiated only under `ALU_HS_MUL_EN`.
- Top level contains the combinational single-cycle datapath, the FSM and the output registers.

## Test plan
- **add:** `op`=0000, a=5, b=4, `out_ready`=1 → result=9, `illegal`=0, `out_valid` on the edge after accept.
- **Shifts:**
  - sra a=-400, b=16 → 0xFFFFFFFF.
  - srl a=-400, b=16 → 0x0000FFFF.
  - sll a=1, b=33 → 2 (shift amount masked to 1).
- **Compare:**
  - slt a=-77, b=5528 → 1.
  - sltu on the same operands → 0.
  - Back-to-back issue of the two gives results on consecutive cycles.
- **mul:**
  - a=749, b=619 → 463631 after exactly 33 cycles, with `in_ready`=0 throughout.
  - a=-3, b=7 → 0xFFFFFFEB.
  - Without `ALU_HS_MUL_EN`: result=0, `illegal`=1 after 1 cycle.
- **Backpressure:** hold `out_ready`=0 for 3 cycles after an add completes → `result` stable, `in_ready`=0. Releasing it while a new `in_valid` is presented retires and accepts on the same edge.
- **Reset and illegal:**
  - Assert `rst` 10 cycles into a mul → next edge `out_valid`=0, `result`=0, and no result is ever emitted.
  - `op`=1100 → `illegal`=1, result=0.
